// File: rtl/cfu_pkg.sv
// Shared CFU command types: widths and the packed command payload.
package cfu_pkg;

  localparam int unsigned CFU_FUNC_ID_W = 10;
  localparam int unsigned CFU_DATA_W    = 32;

  typedef struct packed {
    logic [CFU_FUNC_ID_W-1:0] function_id;
    logic [CFU_DATA_W-1:0]    inputs_0;
    logic [CFU_DATA_W-1:0]    inputs_1;
  } cfu_cmd_t;

endpackage

// File: rtl/cfu_fifo_mem.sv
// Command storage: one write port plus a registered head read.
// The head read forwards same-cycle writes and reads zero when the queue goes empty.
module cfu_fifo_mem
  import cfu_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  cfu_cmd_t      wr_data,
  input  logic [AW-1:0] rd_addr,
  input  logic          rd_clr,
  output cfu_cmd_t      rd_data
);

  cfu_cmd_t mem_q [DEPTH];

  // Storage is deliberately left unreset.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_addr] <= wr_data;
  end

  // Head register tracks the entry that will be at the read pointer after this edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_data <= '0;
    end else if (rd_clr) begin
      rd_data <= '0;
    end else if (wr_en && (wr_addr == rd_addr)) begin
      rd_data <= wr_data;
    end else begin
      rd_data <= mem_q[rd_addr];
    end
  end

endmodule

// File: rtl/cfu_cmd_queue.sv
// Registered command FIFO between the CPU and a combinational CFU.
// Breaks the ready coupling: s_cmd_ready depends only on registered occupancy.
module cfu_cmd_queue
  import cfu_pkg::*;
#(
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned FUNC_ID_W = CFU_FUNC_ID_W,
  parameter int unsigned DATA_W    = CFU_DATA_W
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush,
  input  logic                       s_cmd_valid,
  output logic                       s_cmd_ready,
  input  logic [FUNC_ID_W-1:0]       s_cmd_payload_function_id,
  input  logic [DATA_W-1:0]          s_cmd_payload_inputs_0,
  input  logic [DATA_W-1:0]          s_cmd_payload_inputs_1,
  output logic                       m_cmd_valid,
  input  logic                       m_cmd_ready,
  output logic [FUNC_ID_W-1:0]       m_cmd_payload_function_id,
  output logic [DATA_W-1:0]          m_cmd_payload_inputs_0,
  output logic [DATA_W-1:0]          m_cmd_payload_inputs_1,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push;
  logic             pop;
  cfu_cmd_t         s_cmd;
  cfu_cmd_t         head;

  assign s_cmd.function_id = CFU_FUNC_ID_W'(s_cmd_payload_function_id);
  assign s_cmd.inputs_0    = CFU_DATA_W'(s_cmd_payload_inputs_0);
  assign s_cmd.inputs_1    = CFU_DATA_W'(s_cmd_payload_inputs_1);

  // Next pointer/occupancy; flush discards any same-cycle push or pop.
  always_comb begin
    push     = s_cmd_valid && s_cmd_ready;
    pop      = m_cmd_valid && m_cmd_ready;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      s_cmd_ready <= 1'b1;
      m_cmd_valid <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      s_cmd_ready <= (count_d != CNT_W'(DEPTH));
      m_cmd_valid <= (count_d != '0);
    end
  end

  cfu_fifo_mem #(
    .DEPTH (DEPTH),
    .AW    (PTR_W)
  ) u_mem (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (push && !flush),
    .wr_addr (wr_ptr_q),
    .wr_data (s_cmd),
    .rd_addr (rd_ptr_d),
    .rd_clr  (count_d == '0),
    .rd_data (head)
  );

  assign count                     = count_q;
  assign m_cmd_payload_function_id = FUNC_ID_W'(head.function_id);
  assign m_cmd_payload_inputs_0    = DATA_W'(head.inputs_0);
  assign m_cmd_payload_inputs_1    = DATA_W'(head.inputs_1);

endmodule

// File: tb/tb_cfu_cmd_queue.sv
// Scoreboard bench for cfu_cmd_queue: accepted commands are queued and
// compared in order against the head; occupancy and flags checked every cycle.
module tb_cfu_cmd_queue;
  import cfu_pkg::*;

  localparam int unsigned DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        flush;
  logic        s_cmd_valid;
  logic        s_cmd_ready;
  logic [9:0]  s_fid;
  logic [31:0] s_in0;
  logic [31:0] s_in1;
  logic        m_cmd_valid;
  logic        m_cmd_ready;
  logic [9:0]  m_fid;
  logic [31:0] m_in0;
  logic [31:0] m_in1;
  logic [2:0]  count;

  int n_chk  = 0;
  int n_fail = 0;

  cfu_cmd_t sb[$];

  cfu_cmd_queue #(.DEPTH(DEPTH)) dut (
    .clk                       (clk),
    .reset                     (reset),
    .flush                     (flush),
    .s_cmd_valid               (s_cmd_valid),
    .s_cmd_ready               (s_cmd_ready),
    .s_cmd_payload_function_id (s_fid),
    .s_cmd_payload_inputs_0    (s_in0),
    .s_cmd_payload_inputs_1    (s_in1),
    .m_cmd_valid               (m_cmd_valid),
    .m_cmd_ready               (m_cmd_ready),
    .m_cmd_payload_function_id (m_fid),
    .m_cmd_payload_inputs_0    (m_in0),
    .m_cmd_payload_inputs_1    (m_in1),
    .count                     (count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [79:0] got, input logic [79:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Mid-cycle monitor: check state against the model, then apply this edge's handshakes.
  always @(negedge clk) begin
    if (reset !== 1'b1) begin
      sb.delete();
    end else begin
      check("mon_count", 80'(count), 80'(sb.size()));
      check("mon_s_ready", 80'(s_cmd_ready), 80'(sb.size() != DEPTH));
      check("mon_m_valid", 80'(m_cmd_valid), 80'(sb.size() != 0));
      if (m_cmd_valid && sb.size() > 0)
        check("mon_head", 80'({m_fid, m_in0, m_in1}), 80'(sb[0]));
      if (flush) begin
        sb.delete();
      end else begin
        if (m_cmd_valid && m_cmd_ready && sb.size() > 0) void'(sb.pop_front());
        if (s_cmd_valid && s_cmd_ready) sb.push_back('{s_fid, s_in0, s_in1});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic push_one(input logic [9:0] fid, input logic [31:0] a, input logic [31:0] b);
    s_cmd_valid = 1'b1;
    s_fid = fid;
    s_in0 = a;
    s_in1 = b;
    cyc();
    s_cmd_valid = 1'b0;
  endtask

  initial begin
    reset = 1'b0;
    flush = 1'b0;
    s_cmd_valid = 1'b0;
    s_fid = '0;
    s_in0 = '0;
    s_in1 = '0;
    m_cmd_ready = 1'b0;
    repeat (3) cyc();
    reset = 1'b1;
    cyc();
    check("rst_s_ready", 80'(s_cmd_ready), 80'(1));
    check("rst_m_valid", 80'(m_cmd_valid), 80'(0));
    check("rst_count", 80'(count), 80'(0));
    check("rst_payload", 80'({m_fid, m_in0, m_in1}), 80'(0));

    // Single command, held then popped
    push_one(10'h001, 32'h04030201, 32'h08070605);
    check("single_valid", 80'(m_cmd_valid), 80'(1));
    check("single_count", 80'(count), 80'(1));
    check("single_payload", 80'({m_fid, m_in0, m_in1}), {6'd0, 10'h001, 32'h04030201, 32'h08070605});
    for (int k = 0; k < 5; k++) begin
      cyc();
      check("single_hold", 80'({m_fid, m_in0, m_in1}), {6'd0, 10'h001, 32'h04030201, 32'h08070605});
    end
    m_cmd_ready = 1'b1;
    cyc();
    m_cmd_ready = 1'b0;
    check("single_pop_count", 80'(count), 80'(0));
    check("single_pop_valid", 80'(m_cmd_valid), 80'(0));

    // Fill to full; the fifth push must be refused
    for (int i = 0; i < 5; i++) begin
      push_one(10'(i), $urandom, $urandom);
      if (i == 3) check("fill_ready_low", 80'(s_cmd_ready), 80'(0));
    end
    check("fill_count", 80'(count), 80'(4));
    for (int i = 0; i < 4; i++) begin
      check("fill_order", 80'(m_fid), 80'(i));
      m_cmd_ready = 1'b1;
      cyc();
      m_cmd_ready = 1'b0;
    end
    check("fill_drained", 80'(count), 80'(0));

    // Full with simultaneous pop and push
    for (int i = 0; i < 4; i++) push_one(10'(8 + i), $urandom, $urandom);
    m_cmd_ready = 1'b1;
    s_cmd_valid = 1'b1;
    s_fid = 10'h3ff;
    cyc();
    s_cmd_valid = 1'b0;
    m_cmd_ready = 1'b0;
    check("full_pop_count", 80'(count), 80'(3));
    check("full_pop_ready", 80'(s_cmd_ready), 80'(1));
    m_cmd_ready = 1'b1;
    for (int k = 0; k < 10 && count != 0; k++) cyc();
    m_cmd_ready = 1'b0;
    check("full_drain", 80'(count), 80'(0));

    // Streaming with pointer wrap
    m_cmd_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      push_one(10'(i + 32), 32'(i), ~32'(i));
      check("stream_count", 80'(count), 80'(1));
      check("stream_head", 80'(m_in0), 80'(i));
    end
    cyc();
    check("stream_end", 80'(count), 80'(0));
    m_cmd_ready = 1'b0;

    // Flush beats a same-cycle push
    for (int i = 0; i < 3; i++) push_one(10'(100 + i), $urandom, $urandom);
    check("pre_flush_count", 80'(count), 80'(3));
    flush = 1'b1;
    s_cmd_valid = 1'b1;
    cyc();
    flush = 1'b0;
    s_cmd_valid = 1'b0;
    check("flush_count", 80'(count), 80'(0));
    check("flush_valid", 80'(m_cmd_valid), 80'(0));

    // Asynchronous reset mid-cycle
    for (int i = 0; i < 2; i++) push_one(10'(200 + i), $urandom, $urandom);
    check("pre_rst_count", 80'(count), 80'(2));
    #2;
    reset = 1'b0;
    #1;
    check("arst_count", 80'(count), 80'(0));
    check("arst_valid", 80'(m_cmd_valid), 80'(0));
    check("arst_ready", 80'(s_cmd_ready), 80'(1));
    check("arst_payload", 80'({m_fid, m_in0, m_in1}), 80'(0));
    cyc();
    reset = 1'b1;
    cyc();
    push_one(10'h155, 32'hdeadbeef, 32'h12345678);
    check("post_rst_payload", 80'({m_fid, m_in0, m_in1}), {6'd0, 10'h155, 32'hdeadbeef, 32'h12345678});
    m_cmd_ready = 1'b1;
    cyc();
    m_cmd_ready = 1'b0;
    check("post_rst_count", 80'(count), 80'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
